// File: rtl/tff_toggle_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tff_toggle_sequencer
// Purpose  : Drives a T flip-flop with N one-cycle pulses spaced P cycles apart.
// Revision : 1.0 - initial release
// ============================================================================
module tff_toggle_sequencer #(
  parameter int CNT_W = 8,
  parameter int PER_W = 8
) (
  input  logic             clk,
  input  logic             rst_async,
  input  logic             start,
  input  logic [CNT_W-1:0] num_toggles,
  input  logic [PER_W-1:0] period,
  input  logic             abort,
  output logic             t_out,
  output logic             q,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] remaining
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [PER_W-1:0] last_q, last_d;
  logic [PER_W-1:0] cnt_q, cnt_d;
  logic [PER_W-1:0] cnt_inc;
  logic             t_q, t_d;
  logic             tff_q, tff_d;
  logic             accept;
  logic             per_le1;

  assign accept  = start & ~abort;
  assign per_le1 = (period <= PER_W'(1));
  // cnt_q tracks (i+1) mod P for busy cycle i; last_q holds P-1
  assign cnt_inc = (cnt_q == last_q) ? '0 : cnt_q + PER_W'(1);

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      state_q <= IDLE;
      rem_q   <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
      t_q     <= 1'b0;
      tff_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      t_q     <= t_d;
      tff_q   <= tff_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    t_d     = 1'b0;
    tff_d   = tff_q ^ t_q;
    case (state_q)
      IDLE, FIN: begin
        state_d = IDLE;
        rem_d   = '0;
        cnt_d   = '0;
        if (accept) begin
          if (num_toggles == '0) begin
            state_d = FIN;
          end else begin
            state_d = RUN;
            rem_d   = num_toggles;
            last_d  = per_le1 ? '0 : period - PER_W'(1);
            cnt_d   = per_le1 ? '0 : PER_W'(1);
            t_d     = per_le1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          rem_d   = '0;
          cnt_d   = '0;
        end else if (t_q && rem_q <= CNT_W'(1)) begin
          state_d = FIN;
          rem_d   = '0;
          cnt_d   = '0;
        end else begin
          if (t_q) begin
            rem_d = rem_q - CNT_W'(1);
          end
          cnt_d = cnt_inc;
          t_d   = (cnt_inc == '0);
        end
      end
      default: begin
        state_d = IDLE;
        rem_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  assign t_out     = t_q;
  assign q         = tff_q;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == FIN);
  assign remaining = rem_q;

endmodule
`default_nettype wire
